ps2_key_fifo: RTL and testbench
===============================

PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: clk cycles ps2k_clk must hold a level before that level is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles allowed between PS/2 edges inside a frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two ≥ 2: number of key events buffered.
REQ-004 SHALL have port clk  input  1: sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port ps2k_clk  input  1: PS/2 clock line, asynchronous to clk.
REQ-007 SHALL have port ps2k_data  input  1: PS/2 data line, asynchronous to clk.
REQ-008 SHALL have port ev_valid  output  1: FIFO head holds an event.
REQ-009 SHALL have port ev_ready  input  1: consumer accepts head when ev_valid & ev_ready.
REQ-010 SHALL have port ev_code  output  8: scan code of head event.
REQ-011 SHALL have port ev_ext  output  1: head event was E0-prefixed.
REQ-012 SHALL have port ev_break  output  1: head event is a release (F0-prefixed).
REQ-013 SHALL have port key_held  output  1: last decoded event was a make, not a break.
REQ-014 SHALL have port parity_err  output  1: one-cycle pulse on a frame with bad odd parity.
REQ-015 SHALL have port frame_err  output  1: one-cycle pulse on stop bit = 0, start bit = 1, or timeout.
REQ-016 SHALL have port overflow  output  1: one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-017 SHALL pass both PS/2 lines through 2-flop synchronisers; ps2k_clk then through the FILTER_LEN stability filter.
REQ-018 SHALL generate a one-cycle fall strobe on the filtered clock 1→0 transition; ps2k_data (synchronised) is sampled only on that strobe.
REQ-019 SHALL use receiver FSM states IDLE, DATA, PARITY, STOP; IDLE→DATA on strobe with data=0, DATA→PARITY after 8th bit (LSB first), PARITY→STOP on next strobe, STOP→IDLE on next strobe.
REQ-020 SHALL, on a strobe in IDLE with data=1, stay IDLE and pulse frame_err.
REQ-021 SHALL, in STOP, accept the byte only if parity (8 data bits + parity bit) is odd and stop=1; otherwise discard it and pulse parity_err (parity bad) or frame_err (stop bad); both may pulse together.
REQ-022 SHALL count clk cycles since last strobe while not IDLE; at TIMEOUT_CYCLES, return to IDLE, discard the partial byte, pulse frame_err.
REQ-023 SHALL decode accepted bytes: E0 sets ext flag, F0 sets brk flag, no event; any other byte forms event {ext, brk, code} and clears both flags.
REQ-024 SHALL update key_held on each formed event: 1 if brk=0, 0 if brk=1.
REQ-025 SHALL write the event to the FIFO the cycle after the stop-bit strobe; ev_valid rises the following cycle when FIFO was empty (stop strobe at N → ev_valid at N+2).
REQ-026 SHALL present head event combinationally from FIFO storage (first-word fall-through); ev_code/ev_ext/ev_break are 0 when ev_valid=0.
REQ-027 SHALL pop head on ev_valid & ev_ready; ev_ready with ev_valid=0 has no effect.
REQ-028 SHALL, on write while full and no pop that cycle, drop the new event, pulse overflow, leave FIFO unchanged; write with simultaneous pop while full is accepted.
REQ-029 SHALL keep pointers log2(FIFO_DEPTH)+1 bits wide, wrapping modulo 2·FIFO_DEPTH; full/empty from MSB comparison.
REQ-030 SHALL never lose or reorder accepted events below capacity.

Reset
REQ-031 SHALL, while reset=1, force FSM to IDLE, clear filter, timeout counter, ext/brk flags, FIFO pointers; all outputs 0.
REQ-032 SHALL, on reset mid-frame, discard the partial byte and any pending E0/F0 prefix; reception resumes on the next start bit after reset release.

Verification
REQ-033 SHALL verify: frame 0x1C valid parity → one event code=1C ext=0 break=0, key_held=1, ev_valid at stop-strobe+2.
REQ-034 SHALL verify: bytes E0,F0,75 → single event code=75 ext=1 break=1, key_held=0.
REQ-035 SHALL verify: 0x1C with even parity → parity_err pulse, no event; next good frame decodes normally.
REQ-036 SHALL verify: ev_ready=0, FIFO_DEPTH+1 frames → FIFO_DEPTH events retained in order, one overflow pulse; drain returns them in order.
REQ-037 SHALL verify: ps2k_clk stopped after 4 data bits → frame_err at TIMEOUT_CYCLES, FSM IDLE, next frame received correctly.
REQ-038 SHALL verify: reset asserted mid-frame after E0 prefix → all outputs 0; next byte 0x1D yields event ext=0.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver: synchronise and filter the lines, frame bytes, fold E0/F0 prefixes
// into key events, and buffer the events in a first-word fall-through FIFO.
module ps2_key_fifo #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       key_held,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_ev_t;

    logic c_s1, c_s2, d_s1, d_s2;
    logic filt, filt_q, fall;
    logic [FW-1:0] flt_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {c_s1, c_s2, d_s1, d_s2} <= '0;
            filt    <= 1'b0;
            filt_q  <= 1'b0;
            flt_cnt <= '0;
        end else begin
            c_s1   <= ps2k_clk;
            c_s2   <= c_s1;
            d_s1   <= ps2k_data;
            d_s2   <= d_s1;
            filt_q <= filt;
            // a new level must be seen FILTER_LEN consecutive cycles before it is taken
            if (c_s2 != filt) begin
                if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt    <= c_s2;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FW'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall = filt_q & ~filt;

    rx_state_t state, state_n;
    logic [TW-1:0] tcnt;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic par, frame_done, start_bad, tmo, par_ok, good;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        frame_done = 1'b0;
        start_bad  = 1'b0;
        tmo        = 1'b0;
        if (fall) begin
            case (state)
                IDLE:   if (!d_s2) state_n = DATA; else start_bad = 1'b1;
                DATA:   if (bitcnt == 3'd7) state_n = PARITY;
                PARITY: state_n = STOP;
                STOP:   begin state_n = IDLE; frame_done = 1'b1; end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            tmo     = 1'b1;
        end
    end

    assign par_ok = ^{shreg, par};
    assign good   = frame_done & par_ok & d_s2;

    logic    ext, brk, wr_en;
    key_ev_t wr_ev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt       <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            par        <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            wr_en      <= 1'b0;
            wr_ev      <= '0;
            key_held   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            tcnt       <= (state == IDLE || fall) ? '0 : tcnt + TW'(1);
            parity_err <= frame_done & ~par_ok;
            frame_err  <= start_bad | tmo | (frame_done & ~d_s2);
            wr_en      <= 1'b0;
            if (fall && state == IDLE) bitcnt <= '0;
            if (fall && state == DATA) begin
                shreg  <= {d_s2, shreg[7:1]};
                bitcnt <= bitcnt + 3'd1;
            end
            if (fall && state == PARITY) par <= d_s2;
            if (good) begin
                if (shreg == 8'hE0)      ext <= 1'b1;
                else if (shreg == 8'hF0) brk <= 1'b1;
                else begin
                    wr_en    <= 1'b1;
                    wr_ev    <= '{ext: ext, brk: brk, code: shreg};
                    key_held <= ~brk;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end
            end
        end
    end

    // one extra pointer bit separates full from empty when the indices match
    key_ev_t mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic empty, full, pop, push;
    key_ev_t head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = ~empty & ev_ready;
    assign push  = wr_en & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wr_ev;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en & full & ~pop;
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    assign head     = mem[rptr[AW-1:0]];
    assign ev_valid = ~empty;
    assign ev_code  = ev_valid ? head.code : 8'h00;
    assign ev_ext   = ev_valid & head.ext;
    assign ev_break = ev_valid & head.brk;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: bit-banged PS/2 frames, hand-computed events and pulse counts.
module tb_ps2_key_fifo;
    localparam int FL = 4, TMO = 300, DEPTH = 4, H = 10;

    logic clk = 0, reset = 1, ps2k_clk = 1, ps2k_data = 1, ev_ready = 0;
    logic ev_valid, ev_ext, ev_break, key_held, parity_err, frame_err, overflow;
    logic [7:0] ev_code;

    ps2_key_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .key_held(key_held), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    logic v7, v8;

    always @(negedge clk) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (overflow)   n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // one PS/2 bit: data set while the line is high, then a low phase of H cycles
    task automatic clk_bit(input logic d);
        ps2k_data = d;
        repeat (H) @(negedge clk);
        ps2k_clk = 0;
        for (int k = 1; k <= H; k++) begin
            @(negedge clk);
            if (k == 7) v7 = ev_valid;
            if (k == 8) v8 = ev_valid;
        end
        ps2k_clk = 1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par = 0, input logic stop = 1);
        logic p;
        p = ~(^b) ^ bad_par;
        clk_bit(1'b0);
        for (int i = 0; i < 8; i++) clk_bit(b[i]);
        clk_bit(p);
        clk_bit(stop);
        ps2k_data = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        ev_ready = 1;
        @(negedge clk);
        ev_ready = 0;
    endtask

    task automatic chk_ev(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        chk({tag, "_valid"}, ev_valid, 1);
        chk({tag, "_code"}, ev_code, code);
        chk({tag, "_ext"}, ev_ext, ext);
        chk({tag, "_brk"}, ev_break, brk);
    endtask

    initial begin
        int p0, f0, o0;
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h16, 8'h1A, 8'h1B, 8'h1D};

        repeat (3) @(negedge clk);
        chk("rst_outs", {ev_valid, ev_code, ev_ext, ev_break, key_held, parity_err, frame_err, overflow}, 0);
        reset = 0;
        repeat (20) @(negedge clk);

        // make code 1C, ev_valid two cycles after the stop strobe
        send(8'h1C);
        chk("lat_n1", v7, 0);
        chk("lat_n2", v8, 1);
        chk_ev("mk1c", 8'h1C, 0, 0);
        chk("held_1c", key_held, 1);
        pop();
        chk("empty_1c", ev_valid, 0);
        chk("code0_empty", ev_code, 0);

        // E0 F0 75 folds into one extended break
        send(8'hE0); send(8'hF0);
        chk("no_ev_prefix", ev_valid, 0);
        send(8'h75);
        chk_ev("brk75", 8'h75, 1, 1);
        chk("held_75", key_held, 0);
        pop();
        chk("single_75", ev_valid, 0);

        // bad parity dropped, then a good frame
        p0 = n_perr; f0 = n_ferr;
        send(8'h1C, 1);
        chk("perr_cnt", n_perr - p0, 1);
        chk("perr_noev", ev_valid, 0);
        send(8'h1C);
        chk_ev("after_perr", 8'h1C, 0, 0);
        pop();

        // stop bit 0 and start bit 1 both report framing errors
        send(8'h1C, 0, 0);
        chk("stop_ferr", n_ferr - f0, 1);
        chk("stop_noev", ev_valid, 0);
        clk_bit(1'b1);
        repeat (10) @(negedge clk);
        chk("start_ferr", n_ferr - f0, 2);
        chk("ferr_no_perr", n_perr - p0, 1);

        // DEPTH+1 frames with no consumer: the last one is dropped
        o0 = n_ovf;
        for (int i = 0; i < 5; i++) send(codes[i]);
        chk("ovf_cnt", n_ovf - o0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk_ev($sformatf("drain%0d", i), codes[i], 0, 0);
            pop();
        end
        chk("drain_empty", ev_valid, 0);

        // frame stalls after four data bits
        f0 = n_ferr;
        clk_bit(1'b0);
        for (int i = 0; i < 4; i++) clk_bit(1'b1);
        repeat (TMO + 50) @(negedge clk);
        chk("tmo_ferr", n_ferr - f0, 1);
        chk("tmo_noev", ev_valid, 0);
        send(8'h1B);
        chk_ev("after_tmo", 8'h1B, 0, 0);
        chk("tmo_ferr_once", n_ferr - f0, 1);
        pop();

        // reset mid-frame after an E0 prefix
        send(8'hE0);
        clk_bit(1'b0); clk_bit(1'b1); clk_bit(1'b0);
        reset = 1;
        repeat (2) @(negedge clk);
        chk("mid_rst_outs", {ev_valid, ev_code, ev_ext, ev_break, key_held, parity_err, frame_err, overflow}, 0);
        reset = 0;
        repeat (20) @(negedge clk);
        send(8'h1D);
        chk_ev("post_rst", 8'h1D, 0, 0);
        chk("post_rst_held", key_held, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
